// File: rtl/dma_stats_pkg.sv
// Shared types and helpers for the MAC receive statistics monitor.
package dma_stats_pkg;

    localparam int CNT_W      = 32;
    localparam int TS_W       = 64;
    localparam int KEEP_W_MAX = 64;
    localparam int POP_W      = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_PKT   = 2'd1,
        OVERSIZE = 2'd2
    } rx_state_e;

    // Number of enabled bytes in a (zero-extended) tkeep vector.
    function automatic logic [POP_W-1:0] popcount_keep(input logic [KEEP_W_MAX-1:0] keep);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W_MAX; i++) begin
            n = n + POP_W'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mac_rx_stats_stat_counter.sv
// Wrapping event counter with a synchronous clear that beats the increment.
module stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mac_rx_stats.sv
// Passive receive-stream monitor: SOP timestamp plus word, good and errored packet counters.
//   state    | meaning
//   IDLE     | between packets, next beat is a SOP
//   IN_PKT   | inside a packet, length still within bounds
//   OVERSIZE | inside a packet already longer than MAX_PKT_BYTES
module mac_rx_stats
    import dma_stats_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int MIN_PKT_BYTES = 60,
    parameter int MAX_PKT_BYTES = 1518,
    parameter int LEN_W         = 16
) (
    input  logic                  rx_clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    input  logic                  stat_clr,
    output logic [TS_W-1:0]       stat_mac_rx_ts,
    output logic [CNT_W-1:0]      stat_mac_rx_word_cnt,
    output logic [CNT_W-1:0]      stat_mac_rx_pkt_cnt,
    output logic [CNT_W-1:0]      stat_mac_rx_err_cnt
);

    rx_state_e        state_q, state_d;
    logic [TS_W-1:0]  ts_cnt;
    logic [LEN_W-1:0] len_q, len_acc, len_nxt;
    logic [LEN_W:0]   sum_ext;
    logic [POP_W-1:0] pop;
    logic             beat, too_long, too_short, pkt_err, pkt_inc, err_inc;
    logic             unused_data;

    assign unused_data = ^s_tdata;
    assign beat        = s_tvalid & s_tready;
    assign pop         = popcount_keep(KEEP_W_MAX'(s_tkeep));

    // Running byte length saturates instead of wrapping so giant packets stay oversize.
    assign sum_ext   = {1'b0, len_q} + (LEN_W+1)'(pop);
    assign len_acc   = sum_ext[LEN_W] ? '1 : sum_ext[LEN_W-1:0];
    assign len_nxt   = (state_q == IDLE) ? LEN_W'(pop) : len_acc;
    assign too_long  = len_nxt > LEN_W'(MAX_PKT_BYTES);
    assign too_short = len_nxt < LEN_W'(MIN_PKT_BYTES);
    assign pkt_err   = s_tuser | too_short | too_long | (state_q == OVERSIZE);
    assign pkt_inc   = beat & s_tlast & ~pkt_err;
    assign err_inc   = beat & s_tlast & pkt_err;

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                len_q <= len_nxt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (beat) begin
            case (state_q)
                IDLE:     if (!s_tlast) state_d = IN_PKT;
                IN_PKT:   if (s_tlast) state_d = IDLE;
                          else if (too_long) state_d = OVERSIZE;
                OVERSIZE: if (s_tlast) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            stat_mac_rx_ts <= '0;
        end else if (stat_clr) begin
            stat_mac_rx_ts <= '0;
        end else if (beat && state_q == IDLE) begin
            stat_mac_rx_ts <= ts_cnt;
        end
    end

    stat_counter #(.W(CNT_W)) u_word_cnt (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .inc   (beat),
        .clr   (stat_clr),
        .cnt   (stat_mac_rx_word_cnt)
    );

    stat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .inc   (pkt_inc),
        .clr   (stat_clr),
        .cnt   (stat_mac_rx_pkt_cnt)
    );

    stat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (stat_clr),
        .cnt   (stat_mac_rx_err_cnt)
    );

endmodule

// File: tb/tb_mac_rx_stats.sv
// Randomized bench for mac_rx_stats against a packet-level reference model.
module tb_mac_rx_stats;

    logic        rx_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        stat_clr = 1'b0;
    logic [63:0] stat_mac_rx_ts;
    logic [31:0] stat_mac_rx_word_cnt;
    logic [31:0] stat_mac_rx_pkt_cnt;
    logic [31:0] stat_mac_rx_err_cnt;

    mac_rx_stats dut (
        .rx_clk               (rx_clk),
        .rst_n                (rst_n),
        .s_tdata              (s_tdata),
        .s_tkeep              (s_tkeep),
        .s_tvalid             (s_tvalid),
        .s_tready             (s_tready),
        .s_tlast              (s_tlast),
        .s_tuser              (s_tuser),
        .stat_clr             (stat_clr),
        .stat_mac_rx_ts       (stat_mac_rx_ts),
        .stat_mac_rx_word_cnt (stat_mac_rx_word_cnt),
        .stat_mac_rx_pkt_cnt  (stat_mac_rx_pkt_cnt),
        .stat_mac_rx_err_cnt  (stat_mac_rx_err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    // Cycle count since reset release, as the host would see it at a SOP.
    logic [63:0] tb_ts = '0;
    always @(posedge rx_clk) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 64'd1;
    end

    int          errors = 0;
    int          checks = 0;
    bit          m_in_pkt;
    int          m_bytes;
    logic [31:0] m_word, m_pkt, m_err;
    logic [63:0] m_ts;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_word"}, 64'(stat_mac_rx_word_cnt), 64'(m_word));
        chk({tag, "_pkt"},  64'(stat_mac_rx_pkt_cnt),  64'(m_pkt));
        chk({tag, "_err"},  64'(stat_mac_rx_err_cnt),  64'(m_err));
        chk({tag, "_ts"},   stat_mac_rx_ts,            m_ts);
    endtask

    function automatic int ones(input logic [7:0] k);
        int n = 0;
        for (int i = 0; i < 8; i++) if (k[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_in_pkt = 0; m_bytes = 0;
        m_word = '0; m_pkt = '0; m_err = '0; m_ts = '0;
    endtask

    // Present one cycle of inputs (called just after a falling edge) and update the model.
    task automatic drive(input bit v, input bit r, input bit l, input bit u, input bit c,
                         input logic [7:0] k);
        int b;
        s_tvalid = v; s_tready = r; s_tlast = l; s_tuser = u; s_tkeep = k;
        s_tdata = {$urandom, $urandom}; stat_clr = c;
        if (v && r) begin
            b = ones(k);
            if (!m_in_pkt) begin
                m_bytes = b;
                m_ts = tb_ts;
            end else begin
                m_bytes = (m_bytes + b > 65535) ? 65535 : m_bytes + b;
            end
            m_word++;
            if (l) begin
                if (u || m_bytes < 60 || m_bytes > 1518) m_err++;
                else m_pkt++;
            end
            m_in_pkt = !l;
        end
        if (c) begin
            m_word = '0; m_pkt = '0; m_err = '0; m_ts = '0;
        end
        @(posedge rx_clk);
        @(negedge rx_clk);
        s_tvalid = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 8'($urandom));
    endtask

    task automatic send_pkt(input int nbytes, input bit user, input int stalls, input bit rnd_gap,
                            input bit clr_last);
        int nbeats, rem;
        logic [7:0] k;
        bit last;
        nbeats = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
        rem = nbytes % 8;
        for (int i = 0; i < nbeats; i++) begin
            last = (i == nbeats - 1);
            if (!last || rem == 0) k = 8'hFF;
            else k = 8'((1 << rem) - 1);
            if (nbytes == 0) k = 8'h00;
            if (i >= 1 && i <= stalls) drive(1, 0, 1'($urandom), 1'($urandom), 0, 8'($urandom));
            if (rnd_gap && $urandom_range(0, 7) == 0) begin
                drive(1'($urandom), 0, 1'($urandom), 1'($urandom), 0, 8'($urandom));
                drive(0, 1, 1'($urandom), 1'($urandom), 0, 8'($urandom));
            end
            drive(1, 1, last, last ? user : 1'($urandom), clr_last && last, k);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; stat_clr = 1'b0;
        repeat (2) @(posedge rx_clk);
        @(negedge rx_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(10);
        check_all("reset");
        chk("reset_word_zero", 64'(stat_mac_rx_word_cnt), 64'd0);

        idle(8);
        send_pkt(64, 0, 0, 0, 0);
        check_all("good64");
        chk("good64_pkt_one", 64'(stat_mac_rx_pkt_cnt), 64'd1);

        send_pkt(40, 0, 0, 0, 0);
        check_all("runt40");
        send_pkt(1600, 0, 0, 0, 0);
        check_all("over1600");
        send_pkt(64, 1, 0, 0, 0);
        check_all("tuser64");
        chk("seq_err_three", 64'(stat_mac_rx_err_cnt), 64'd3);

        send_pkt(60, 0, 0, 0, 0);
        check_all("exact60");
        send_pkt(59, 0, 0, 0, 0);
        check_all("runt59");
        send_pkt(1518, 0, 0, 0, 0);
        check_all("max1518");
        send_pkt(1519, 0, 0, 0, 0);
        check_all("over1519");
        send_pkt(0, 0, 0, 0, 0);
        check_all("keep0");

        send_pkt(64, 0, 3, 0, 0);
        check_all("stall3");

        send_pkt(64, 0, 0, 0, 1);
        check_all("clr_on_last");
        chk("clr_pkt_zero", 64'(stat_mac_rx_pkt_cnt), 64'd0);
        send_pkt(64, 0, 0, 0, 0);
        check_all("after_clr");
        chk("after_clr_word", 64'(stat_mac_rx_word_cnt), 64'd8);

        drive(1, 1, 0, 0, 0, 8'hFF);
        drive(1, 1, 0, 0, 0, 8'hFF);
        drive(1, 1, 0, 0, 0, 8'hFF);
        do_reset();
        idle(3);
        send_pkt(64, 0, 0, 0, 0);
        check_all("post_reset_pkt");

        send_pkt(70000, 0, 0, 0, 0);
        check_all("len_saturate");

        force dut.u_word_cnt.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_word_cnt.cnt;
        m_word = 32'hFFFF_FFFF;
        chk("preload_word", 64'(stat_mac_rx_word_cnt), 64'h0000_0000_FFFF_FFFF);
        send_pkt(8, 0, 0, 0, 0);
        check_all("word_wrap");

        for (int p = 0; p < 40; p++) begin
            int nb;
            case ($urandom_range(0, 3))
                0: nb = $urandom_range(0, 70);
                1: nb = $urandom_range(1500, 1600);
                default: nb = $urandom_range(55, 1530);
            endcase
            if ($urandom_range(0, 15) == 0) drive(0, 0, 0, 0, 1, 8'h00);
            send_pkt(nb, ($urandom_range(0, 4) == 0), $urandom_range(0, 2), 1,
                     ($urandom_range(0, 9) == 0));
            idle($urandom_range(0, 3));
            check_all($sformatf("rnd%0d", p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
